// File: rtl/elevator_call_encoder_if.sv
// elevator_call_encoder_if: valid/ready target-floor handshake between call encoder and motion controller
interface elevator_call_encoder_if #(parameter int FW = 3);
  logic          target_valid;
  logic          target_ready;
  logic [FW-1:0] target_floor;
  modport master(output target_valid, target_floor, input target_ready);
  modport slave(input target_valid, target_floor, output target_ready);
endinterface

// File: rtl/elevator_call_encoder.sv
// elevator_call_encoder: latches floor calls and offers the next SCAN target over a valid/ready handshake
module elevator_call_encoder #(
  parameter int FLOOR = 6,
  parameter int FW    = $clog2(FLOOR + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [FLOOR-1:0] call_btn,
  input  logic [FW-1:0]    current_floor,
  input  logic             arrived,
  output logic [FLOOR-1:0] pending,
  output logic             dir_up,
  elevator_call_encoder_if.master tgt
);
  typedef enum logic [1:0] {IDLE, SELECT, OFFER, WAIT_ARRIVE} state_t;
  state_t state;
  logic [FLOOR-1:0] btn_prev, clr, pn;
  logic [FW-1:0] ge_f, gt_f, le_f, lt_f, sel_f;
  logic floor_ok, sel_up;
  assign floor_ok = current_floor != '0 && current_floor <= FW'(FLOOR);
  assign clr = (arrived && floor_ok) ? {{(FLOOR-1){1'b0}}, 1'b1} << (current_floor - FW'(1)) : '0;
  // clear beats a simultaneous rising edge on the same bit
  assign pn = (pending | (call_btn & ~btn_prev)) & ~clr;
  always_comb begin
    ge_f = '0;
    gt_f = '0;
    le_f = '0;
    lt_f = '0;
    for (int i = FLOOR - 1; i >= 0; i--) begin
      if (pn[i] && FW'(i + 1) >= current_floor) ge_f = FW'(i + 1);
      if (pn[i] && FW'(i + 1) > current_floor) gt_f = FW'(i + 1);
    end
    for (int i = 0; i < FLOOR; i++) begin
      if (pn[i] && FW'(i + 1) <= current_floor) le_f = FW'(i + 1);
      if (pn[i] && FW'(i + 1) < current_floor) lt_f = FW'(i + 1);
    end
    sel_f = dir_up ? (ge_f != '0 ? ge_f : lt_f) : (le_f != '0 ? le_f : gt_f);
    sel_up = dir_up ? ge_f != '0 : le_f == '0;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      btn_prev <= '0;
      tgt.target_valid <= 1'b0;
      tgt.target_floor <= FW'(1);
      dir_up <= 1'b1;
      state <= IDLE;
    end else begin
      pending <= pn;
      btn_prev <= call_btn;
      case (state)
        IDLE: if (pending != '0) state <= SELECT;
        SELECT:
          if (pn == '0) state <= IDLE;
          else begin
            tgt.target_floor <= sel_f;
            dir_up <= sel_up;
            tgt.target_valid <= 1'b1;
            state <= OFFER;
          end
        OFFER:
          if (tgt.target_ready) begin
            tgt.target_valid <= 1'b0;
            state <= WAIT_ARRIVE;
          end
        WAIT_ARRIVE: if (arrived && current_floor == tgt.target_floor) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_elevator_call_encoder.sv
// tb_elevator_call_encoder: directed checks of latching, SCAN ordering, handshake hold and async reset
module tb_elevator_call_encoder;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] call_btn = '0;
  logic [2:0] current_floor = 3'd1;
  logic arrived = 1'b0;
  logic [5:0] pending;
  logic dir_up;
  int vectors = 0;
  int miscompares = 0;
  elevator_call_encoder_if #(.FW(3)) bus();
  elevator_call_encoder dut (
    .clock(clock), .rst_n(rst_n), .call_btn(call_btn), .current_floor(current_floor),
    .arrived(arrived), .pending(pending), .dir_up(dir_up), .tgt(bus)
  );
  always #5 clock = ~clock;
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.target_ready = 1'b0;
    tick(2);
    chk("reset_pending", 32'(pending), 32'h00);
    chk("reset_valid", 32'(bus.target_valid), 32'd0);
    chk("reset_floor", 32'(bus.target_floor), 32'd1);
    chk("reset_dir", 32'(dir_up), 32'd1);
    rst_n = 1'b1;
    call_btn = 6'b001000;
    tick();
    call_btn = '0;
    chk("t1_pending", 32'(pending), 32'b001000);
    chk("t1_valid_k", 32'(bus.target_valid), 32'd0);
    tick();
    chk("t1_valid_k1", 32'(bus.target_valid), 32'd0);
    tick();
    chk("t1_valid_k2", 32'(bus.target_valid), 32'd1);
    chk("t1_floor", 32'(bus.target_floor), 32'd4);
    chk("t1_dir", 32'(dir_up), 32'd1);
    bus.target_ready = 1'b1;
    tick();
    bus.target_ready = 1'b0;
    chk("t2_valid_hs", 32'(bus.target_valid), 32'd0);
    current_floor = 3'd4;
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    chk("t2_pending", 32'(pending), 32'h00);
    tick(3);
    chk("t2_idle_valid", 32'(bus.target_valid), 32'd0);
    current_floor = 3'd3;
    call_btn = 6'b010010;
    tick();
    call_btn = '0;
    chk("t3_pending", 32'(pending), 32'b010010);
    tick(2);
    chk("t3_valid1", 32'(bus.target_valid), 32'd1);
    chk("t3_floor1", 32'(bus.target_floor), 32'd5);
    chk("t3_dir1", 32'(dir_up), 32'd1);
    bus.target_ready = 1'b1;
    tick();
    bus.target_ready = 1'b0;
    current_floor = 3'd5;
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    chk("t3_pending2", 32'(pending), 32'b000010);
    tick(2);
    chk("t3_valid2", 32'(bus.target_valid), 32'd1);
    chk("t3_floor2", 32'(bus.target_floor), 32'd2);
    chk("t3_dir2", 32'(dir_up), 32'd0);
    call_btn = 6'b100000;
    tick();
    call_btn = '0;
    tick(9);
    chk("t4_floor_held", 32'(bus.target_floor), 32'd2);
    chk("t4_valid_held", 32'(bus.target_valid), 32'd1);
    chk("t4_pending", 32'(pending), 32'b100010);
    chk("t4_dir_held", 32'(dir_up), 32'd0);
    bus.target_ready = 1'b1;
    tick();
    bus.target_ready = 1'b0;
    current_floor = 3'd2;
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    tick(2);
    chk("t4_floor_rev", 32'(bus.target_floor), 32'd6);
    chk("t4_dir_rev", 32'(dir_up), 32'd1);
    chk("t4_valid_rev", 32'(bus.target_valid), 32'd1);
    current_floor = 3'd3;
    arrived = 1'b1;
    call_btn = 6'b000100;
    tick();
    arrived = 1'b0;
    chk("t5_clear_wins", 32'(pending), 32'b100000);
    tick(3);
    chk("t5_held_no_relatch", 32'(pending), 32'b100000);
    call_btn = '0;
    tick();
    call_btn = 6'b000100;
    tick();
    call_btn = '0;
    chk("t5_relatch", 32'(pending), 32'b100100);
    current_floor = 3'd0;
    arrived = 1'b1;
    tick();
    current_floor = 3'd7;
    tick();
    arrived = 1'b0;
    chk("t5_invalid_floor", 32'(pending), 32'b100100);
    chk("t5_offer_kept", 32'(bus.target_floor), 32'd6);
    call_btn = 6'b010011;
    tick();
    call_btn = '0;
    current_floor = 3'd3;
    arrived = 1'b1;
    tick();
    arrived = 1'b0;
    chk("t6_pending_pre", 32'(pending), 32'b110011);
    bus.target_ready = 1'b1;
    tick();
    bus.target_ready = 1'b0;
    chk("t6_wait_valid", 32'(bus.target_valid), 32'd0);
    call_btn = 6'b000001;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pending", 32'(pending), 32'h00);
    chk("t6_async_floor", 32'(bus.target_floor), 32'd1);
    chk("t6_async_valid", 32'(bus.target_valid), 32'd0);
    chk("t6_async_dir", 32'(dir_up), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_held_through_reset", 32'(pending), 32'b000001);
    call_btn = '0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
